// File: rtl/display_scan_ctrl.sv
// Scan controller for the 4-digit seven-segment display with error hold timer.
// Optional BLINK_ERR_EN blanks every other frame while the error is shown.
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int ERR_FRAMES  = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_err,
    input  logic       clear_err,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] err_code,
    output logic [1:0] sel,
    output logic [3:0] digit_code,
    output logic [3:0] an,
    output logic       dp,
    output logic       err_active
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = $clog2(ERR_FRAMES + 1);
    localparam logic [PW-1:0] PMAX  = PW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FLOAD = FW'(ERR_FRAMES);
    localparam logic [FW-1:0] FONE  = FW'(1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t        state, state_n;
    logic [PW-1:0] pcnt;
    logic [FW-1:0] fcnt;
    logic          tick;
    logic          frame_end;
    logic          load;
    logic          blank;
    logic [3:0]    tdig;

    assign tick      = (pcnt == PMAX);
    assign frame_end = tick && (sel == 2'd3);
    assign err_active = (state == SHOW);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next state; clear beats a new error, a new error beats expiry
    always_comb begin
        state_n = state;
        load    = 1'b0;
        if (clear_err) begin
            state_n = IDLE;
        end else if (mode_err) begin
            state_n = SHOW;
            load    = 1'b1;
        end else if (state == SHOW && frame_end && fcnt == FONE) begin
            state_n = IDLE;
        end
    end

    // Prescaler and digit select; an error restarts the scan at a frame edge
    always_ff @(posedge clk) begin
        if (reset || load) begin
            pcnt <= '0;
            sel  <= 2'd0;
        end else if (tick) begin
            pcnt <= '0;
            sel  <= sel + 2'd1;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Remaining frames of the error hold
    always_ff @(posedge clk) begin
        if (reset)
            fcnt <= '0;
        else if (load)
            fcnt <= FLOAD;
        else if (clear_err)
            fcnt <= '0;
        else if (state == SHOW && frame_end)
            fcnt <= fcnt - FONE;
    end

`ifdef BLINK_ERR_EN
    logic blank_q;

    // Frame parity since error entry; the first frame is lit
    always_ff @(posedge clk) begin
        if (reset || load)
            blank_q <= 1'b0;
        else if (frame_end)
            blank_q <= ~blank_q;
    end

    assign blank = err_active && blank_q;
`else
    assign blank = 1'b0;
`endif

    // Time digit for the current slot
    always_comb begin
        tdig = digit0;
        unique case (sel)
            2'd0: tdig = digit0;
            2'd1: tdig = digit1;
            2'd2: tdig = digit2;
            2'd3: tdig = digit3;
        endcase
    end

    // Display outputs from registered state
    always_comb begin
        an         = ~(4'b0001 << sel);
        dp         = 1'b1;
        digit_code = err_active ? err_code : tdig;
        if (sel == 2'd2 && !err_active)
            dp = 1'b0;
        if (blank) begin
            an = 4'b1111;
            dp = 1'b1;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized scoreboard bench for display_scan_ctrl.
// Reference model tracks scan phase and remaining error cycles.
module tb_display_scan_ctrl;

    localparam int RD   = 4;
    localparam int EF   = 3;
    localparam int FR   = 4 * RD;
    localparam int HOLD = EF * FR;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode_err;
    logic       clear_err;
    logic [3:0] digs [4];
    logic [3:0] err_code;
    logic [1:0] sel;
    logic [3:0] digit_code;
    logic [3:0] an;
    logic       dp;
    logic       err_active;

    typedef struct {
        int slot;
        bit active;
        bit blank;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    int phase = 0;
    int left  = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] emap(input int s);
        case (s)
            0:       return 4'h1;
            1:       return 4'h0;
            2:       return 4'hE;
            default: return 4'hF;
        endcase
    endfunction

    // error-code mux environment, driven by the DUT's own select
    assign err_code = emap(int'(sel));

    display_scan_ctrl #(
        .REFRESH_DIV(RD),
        .ERR_FRAMES (EF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode_err  (mode_err),
        .clear_err (clear_err),
        .digit0    (digs[0]),
        .digit1    (digs[1]),
        .digit2    (digs[2]),
        .digit3    (digs[3]),
        .err_code  (err_code),
        .sel       (sel),
        .digit_code(digit_code),
        .an        (an),
        .dp        (dp),
        .err_active(err_active)
    );

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, req, $time);
        end
    endtask

    // model: advance one clock with the inputs held before the edge
    task automatic model_edge();
        if (reset) begin
            phase = 0;
            left  = 0;
        end else begin
            phase = (phase + 1) % FR;
            if (left > 0) left--;
            if (clear_err) begin
                left = 0;
            end else if (mode_err) begin
                left  = HOLD;
                phase = 0;
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.slot   = phase / RD;
        e.active = (left > 0);
        e.blank  = 1'b0;
`ifdef BLINK_ERR_EN
        if (left > 0 && (((HOLD - left) / FR) % 2 == 1))
            e.blank = 1'b1;
`endif
        q.push_back(e);
    endtask

    task automatic step(input bit m, input bit c, input bit r);
        mode_err  = m;
        clear_err = c;
        reset     = r;
        @(posedge clk);
        model_edge();
        #1;
        mode_err  = 1'b0;
        clear_err = 1'b0;
        reset     = 1'b0;
        for (int i = 0; i < 4; i++) digs[i] = 4'($urandom_range(0, 9));
        push_exp();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // monitor: compare DUT outputs mid-cycle against the queued model state
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [3:0] ean;
            logic [3:0] edc;
            logic       edp;
            e   = q.pop_front();
            ean = e.blank ? 4'b1111 : ~(4'b0001 << e.slot);
            edc = e.active ? emap(e.slot) : digs[e.slot];
            edp = (e.slot == 2 && !e.active) ? 1'b0 : 1'b1;
            if (e.blank) edp = 1'b1;
            chk("sel", int'(sel), e.slot);
            chk("an", int'(an), int'(ean));
            chk("err_active", int'(err_active), int'(e.active));
            chk("digit_code", int'(digit_code), int'(edc));
            chk("dp", int'(dp), int'(edp));
        end
    end

    initial begin
        int n;
        mode_err  = 1'b0;
        clear_err = 1'b0;
        reset     = 1'b1;
        digs[0] = 4'd4; digs[1] = 4'd3;
        digs[2] = 4'd2; digs[3] = 4'd1;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        run(40);
        // error raised while slot 2 is lit
        n = 0;
        while (phase / RD != 2 && n < 100) begin
            run(1);
            n++;
        end
        chk("wait_slot2", int'(phase / RD == 2), 1);
        step(1'b1, 1'b0, 1'b0);
        run(60);
        // retrigger 20 cycles in
        step(1'b1, 1'b0, 1'b0);
        run(19);
        step(1'b1, 1'b0, 1'b0);
        run(60);
        // clear beats error in idle, then clear mid-hold
        run(3);
        step(1'b1, 1'b1, 1'b0);
        run(10);
        step(1'b1, 1'b0, 1'b0);
        run(10);
        step(1'b0, 1'b1, 1'b0);
        run(10);
        // retrigger on the final frame edge
        step(1'b1, 1'b0, 1'b0);
        run(HOLD - 1);
        step(1'b1, 1'b0, 1'b0);
        run(HOLD + 4);
        // reset in the middle of a hold, then a fresh error
        step(1'b1, 1'b0, 1'b0);
        run(10);
        step(1'b0, 1'b0, 1'b1);
        run(7);
        step(1'b1, 1'b0, 1'b0);
        run(HOLD + 8);
        // random soak
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 39) == 0,
                 $urandom_range(0, 99) == 0,
                 $urandom_range(0, 299) == 0);
        end
        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
